// File: rtl/conv_width_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_width_ctrl_if
//  Description : Signal bundle between the width-converter sequencer and its
//                neighbours (training/config logic and the 8-bit converter).
//                  byte_valid  - one byte presented to the converter
//                  pclk_req    - requested width select (00=32b 01=16b 10=8b)
//                  req_valid   - width-change request valid
//                  req_ready   - sequencer can take a request this cycle
//                  PCLK        - width select driven to the converter
//                  conv_enb    - converter enable
//                  byte_idx    - slot the next accepted byte fills
//                  word_done   - one-cycle pulse, word completed
//                  err_cfg     - one-cycle pulse, illegal width request
//                  byte_drop   - one-cycle pulse, byte seen while disabled
//                  busy        - sequencer not in its normal run state
//                master : the sequencer (conv_width_ctrl)
//                slave  : the surrounding logic
//  Revision    : 1.0 - initial release
// ============================================================================
interface conv_width_ctrl_if;
   logic       byte_valid;
   logic [1:0] pclk_req;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] PCLK;
   logic       conv_enb;
   logic [1:0] byte_idx;
   logic       word_done;
   logic       err_cfg;
   logic       byte_drop;
   logic       busy;

   modport master (
      input  byte_valid, pclk_req, req_valid,
      output req_ready, PCLK, conv_enb, byte_idx,
             word_done, err_cfg, byte_drop, busy
   );

   modport slave (
      output byte_valid, pclk_req, req_valid,
      input  req_ready, PCLK, conv_enb, byte_idx,
             word_done, err_cfg, byte_drop, busy
   );
endinterface
`default_nettype wire

// File: rtl/conv_width_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : conv_width_ctrl
//  Description : Sequencer for the 8-bit-to-parallel width converter. Owns
//                the PCLK width select, counts byte slots within a word,
//                flags word completion and applies width-change requests
//                only on a word boundary, then holds the converter disabled
//                for a fixed settle window.
//  Ports       : CLK  - clock, rising edge
//                ENB  - asynchronous active-low reset
//                bus  - conv_width_ctrl_if.master (handshake and status)
//  Parameters  : DEFAULT_PCLK - width select loaded at reset
//                SETTLE_CYC   - cycles spent in SETTLE after a switch (1..15)
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_width_ctrl #(
   parameter logic [1:0]  DEFAULT_PCLK = 2'b10,
   parameter int unsigned SETTLE_CYC   = 2
) (
   input  wire logic            CLK,
   input  wire logic            ENB,
   conv_width_ctrl_if.master    bus
);

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_RUN    = 3'd1,
      S_DRAIN  = 3'd2,
      S_SWITCH = 3'd3,
      S_SETTLE = 3'd4
   } state_t;

   localparam logic [3:0] c_settle_load = 4'(SETTLE_CYC - 1);
   localparam logic [1:0] c_sel_bad     = 2'b11;

   state_t     r_state;
   logic [1:0] r_pclk;
   logic [1:0] r_pend;
   logic [1:0] r_idx;
   logic [3:0] r_cnt;
   logic       r_word_done;
   logic       r_err_cfg;
   logic       r_byte_drop;

   state_t     w_state;
   logic [1:0] w_pclk;
   logic [1:0] w_pend;
   logic [1:0] w_idx;
   logic [3:0] w_cnt;
   logic       w_word_done;
   logic       w_err_cfg;
   logic       w_byte_drop;

   logic [1:0] w_lim;
   logic       w_enabled;
   logic       w_accept;
   logic       w_closes;

   // Last slot index of a word for the current width (bytes per word - 1).
   always_comb begin
      w_lim = 2'd0;
      case (r_pclk)
         2'b00:   w_lim = 2'd3;
         2'b01:   w_lim = 2'd1;
         default: w_lim = 2'd0;
      endcase
   end

   assign w_enabled = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign w_accept  = w_enabled && bus.byte_valid;
   // The byte accepted this cycle fills the final slot of the word.
   assign w_closes  = w_accept && (r_idx == w_lim);

   always_ff @(posedge CLK or negedge ENB) begin
      if (!ENB) begin
         r_state     <= S_INIT;
         r_pclk      <= DEFAULT_PCLK;
         r_pend      <= DEFAULT_PCLK;
         r_idx       <= 2'd0;
         r_cnt       <= 4'd0;
         r_word_done <= 1'b0;
         r_err_cfg   <= 1'b0;
         r_byte_drop <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_pclk      <= w_pclk;
         r_pend      <= w_pend;
         r_idx       <= w_idx;
         r_cnt       <= w_cnt;
         r_word_done <= w_word_done;
         r_err_cfg   <= w_err_cfg;
         r_byte_drop <= w_byte_drop;
      end
   end

   always_comb begin
      w_state     = r_state;
      w_pclk      = r_pclk;
      w_pend      = r_pend;
      w_idx       = r_idx;
      w_cnt       = r_cnt;
      w_word_done = 1'b0;
      w_err_cfg   = 1'b0;
      w_byte_drop = 1'b0;

      // Byte counting is shared by RUN and DRAIN and happens before any
      // request decision, so a simultaneous byte counts at the old width.
      if (w_accept) begin
         if (w_closes) begin
            w_idx       = 2'd0;
            w_word_done = 1'b1;
         end else begin
            w_idx = r_idx + 2'd1;
         end
      end

      case (r_state)
         S_INIT: begin
            w_byte_drop = bus.byte_valid;
            w_state     = S_RUN;
         end

         S_RUN: begin
            if (bus.req_valid) begin
               if (bus.pclk_req == c_sel_bad) begin
                  w_err_cfg = 1'b1;
               end else if (bus.pclk_req != r_pclk) begin
                  w_pend = bus.pclk_req;
                  // Switch straight away when already on a word boundary,
                  // either idle at slot 0 or closing the word right now.
                  if (w_closes || (r_idx == 2'd0 && !bus.byte_valid)) begin
                     w_state = S_SWITCH;
                  end else begin
                     w_state = S_DRAIN;
                  end
               end
            end
         end

         S_DRAIN: begin
            if (w_closes) begin
               w_state = S_SWITCH;
            end
         end

         S_SWITCH: begin
            w_byte_drop = bus.byte_valid;
            w_pclk      = r_pend;
            w_idx       = 2'd0;
            w_cnt       = c_settle_load;
            w_state     = S_SETTLE;
         end

         S_SETTLE: begin
            w_byte_drop = bus.byte_valid;
            if (r_cnt == 4'd0) begin
               w_state = S_RUN;
            end else begin
               w_cnt = r_cnt - 4'd1;
            end
         end

         default: begin
            w_state = S_INIT;
         end
      endcase
   end

   assign bus.conv_enb  = w_enabled;
   assign bus.req_ready = (r_state == S_RUN);
   assign bus.busy      = (r_state != S_RUN);
   assign bus.PCLK      = r_pclk;
   assign bus.byte_idx  = r_idx;
   assign bus.word_done = r_word_done;
   assign bus.err_cfg   = r_err_cfg;
   assign bus.byte_drop = r_byte_drop;

endmodule
`default_nettype wire
